// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single DataMemoryManager port: CPU normally wins,
// aux progress is guaranteed by a starvation counter and a bounded burst lock.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic              aux_lock_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_wdata_i,
  output logic              aux_gnt_o,
  output logic              aux_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned BEAT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CPU   = 2'd1,
    S_AUX   = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              force_aux;
  logic              burst_cont;
  logic              beat_last;

  // State register: records who owned the port last cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state follows this cycle's owner; the final locked beat drops to S_AUX
  always_comb begin
    state_next = S_IDLE;
    if (cpu_gnt_o) begin
      state_next = S_CPU;
    end else if (aux_gnt_o) begin
      state_next = (aux_lock_i && !beat_last) ? S_BURST : S_AUX;
    end
  end

  // Grant priority and memory port mux
  always_comb begin
    force_aux     = aux_req_i && (wait_cnt == WAIT_W'(MAX_WAIT));
    burst_cont    = (state == S_BURST) && aux_req_i && aux_lock_i &&
                    (beat_cnt < BEAT_W'(BURST_MAX));
    cpu_gnt_o     = 1'b0;
    aux_gnt_o     = 1'b0;
    mem_address_o = '0;
    mem_data_o    = '0;
    mem_wren_o    = 1'b0;
    if (!RST) begin
      if (force_aux || burst_cont) begin
        aux_gnt_o = 1'b1;
      end else if (cpu_req_i) begin
        cpu_gnt_o = 1'b1;
      end else if (aux_req_i) begin
        aux_gnt_o = 1'b1;
      end
    end
    if (cpu_gnt_o) begin
      mem_address_o = cpu_addr_i;
      mem_data_o    = cpu_wdata_i;
      mem_wren_o    = cpu_we_i;
    end else if (aux_gnt_o) begin
      mem_address_o = aux_addr_i;
      mem_data_o    = aux_wdata_i;
      mem_wren_o    = aux_we_i;
    end
  end

  assign beat_last   = aux_gnt_o && aux_lock_i && (beat_cnt == BEAT_W'(BURST_MAX - 1));
  assign cpu_stall_o = cpu_req_i && !cpu_gnt_o;
  assign rdata_o     = mem_data_i;

  // Starvation counter, burst beat counter and read-valid tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt     <= '0;
      beat_cnt     <= '0;
      cpu_rvalid_o <= 1'b0;
      aux_rvalid_o <= 1'b0;
    end else begin
      if (aux_req_i && !aux_gnt_o) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
      if (aux_gnt_o && aux_lock_i && !beat_last) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end else begin
        beat_cnt <= '0;
      end
      cpu_rvalid_o <= cpu_gnt_o && !cpu_we_i;
      aux_rvalid_o <= aux_gnt_o && !aux_we_i;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a rule-level model.
module tb_data_mem_arbiter;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned BURST_MAX = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic              cpu_req_i, cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_stall_o, cpu_gnt_o, cpu_rvalid_o;
  logic              aux_req_i, aux_we_i, aux_lock_i;
  logic [ADDR_W-1:0] aux_addr_i;
  logic [DATA_W-1:0] aux_wdata_i;
  logic              aux_gnt_o, aux_rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic [ADDR_W-1:0] mem_address_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_wren_o;
  logic [DATA_W-1:0] mem_data_i;

  data_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_stall_o(cpu_stall_o), .cpu_gnt_o(cpu_gnt_o),
    .cpu_rvalid_o(cpu_rvalid_o),
    .aux_req_i(aux_req_i), .aux_we_i(aux_we_i), .aux_lock_i(aux_lock_i),
    .aux_addr_i(aux_addr_i), .aux_wdata_i(aux_wdata_i), .aux_gnt_o(aux_gnt_o),
    .aux_rvalid_o(aux_rvalid_o), .rdata_o(rdata_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_wren_o(mem_wren_o),
    .mem_data_i(mem_data_i)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: aux waiting cycles, locked beats so far, burst flag
  int m_wait  = 0;
  int m_beats = 0;
  bit m_burst = 0;
  bit m_rv_cpu = 0, m_rv_aux = 0;
  bit e_cpu, e_aux;
  bit g_cpu, g_aux, g_stall, g_wren;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: inputs already applied just after a negedge
  task automatic cycle();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              ew;
    #1;
    e_cpu = 0;
    e_aux = 0;
    if (!RST) begin
      if (aux_req_i && (m_wait == MAX_WAIT || (m_burst && aux_lock_i) || !cpu_req_i))
        e_aux = 1;
      else if (cpu_req_i)
        e_cpu = 1;
    end
    ea = e_cpu ? cpu_addr_i  : e_aux ? aux_addr_i  : '0;
    ed = e_cpu ? cpu_wdata_i : e_aux ? aux_wdata_i : '0;
    ew = e_cpu ? cpu_we_i    : e_aux ? aux_we_i    : 1'b0;
    chk("cpu_gnt", cpu_gnt_o, e_cpu);
    chk("aux_gnt", aux_gnt_o, e_aux);
    chk("stall", cpu_stall_o, cpu_req_i && !e_cpu);
    chk("wren", mem_wren_o, ew);
    chk("addr", mem_address_o, ea);
    chk("wdata", mem_data_o, ed);
    chk("rdata", rdata_o, mem_data_i);
    chk("cpu_rvalid", cpu_rvalid_o, m_rv_cpu);
    chk("aux_rvalid", aux_rvalid_o, m_rv_aux);
    g_cpu = cpu_gnt_o; g_aux = aux_gnt_o; g_stall = cpu_stall_o; g_wren = mem_wren_o;
    @(posedge CLK);
    if (RST) begin
      m_wait = 0; m_beats = 0; m_burst = 0; m_rv_cpu = 0; m_rv_aux = 0;
    end else begin
      m_wait = (aux_req_i && !e_aux) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      if (e_aux && aux_lock_i) begin
        m_beats++;
        m_burst = (m_beats < BURST_MAX);
        if (!m_burst) m_beats = 0;
      end else begin
        m_burst = 0;
        m_beats = 0;
      end
      m_rv_cpu = e_cpu && !cpu_we_i;
      m_rv_aux = e_aux && !aux_we_i;
    end
    @(negedge CLK);
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    cpu_req_i = req; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
  endtask

  task automatic set_aux(input bit req, input bit we, input bit lock,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    aux_req_i = req; aux_we_i = we; aux_lock_i = lock; aux_addr_i = a; aux_wdata_i = d;
  endtask

  int  n;
  bit  cpu_pend, aux_pend;

  initial begin
    RST = 1'b1;
    set_cpu(0, 0, '0, '0);
    set_aux(0, 0, 0, '0, '0);
    mem_data_i = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    // Reset state: no grants, idle memory port
    cycle();
    chk("rst_gnt", {g_cpu, g_aux}, 0);
    RST = 1'b0;
    cycle();

    // T1: single CPU read
    set_cpu(1, 0, 100, 0); mem_data_i = 32'h0000_DEAD;
    cycle();
    chk("t1_gnt", g_cpu, 1);
    chk("t1_stall", g_stall, 0);
    set_cpu(0, 0, 0, 0);
    #1;
    chk("t1_rvalid", cpu_rvalid_o, 1);
    chk("t1_rdata", rdata_o, 32'h0000_DEAD);
    cycle();

    // T2: contention from cycle 0, forced aux grant at cycle 4
    set_cpu(1, 0, 32'h40, 0);
    set_aux(1, 0, 0, 32'h80, 0);
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("t2_aux", g_aux, (c == 4));
      chk("t2_cpu", g_cpu, (c != 4));
      if (c == 4) chk("t2_stall", g_stall, 1);
    end
    set_cpu(0, 0, 0, 0); set_aux(0, 0, 0, 0, 0);
    cycle();

    // T3: locked burst under CPU pressure, exactly BURST_MAX aux beats
    set_cpu(1, 1, 32'h44, 32'h11);
    set_aux(1, 1, 1, 32'h88, 32'h22);
    n = 0;
    for (int c = 0; c < MAX_WAIT + BURST_MAX; c++) begin
      cycle();
      n += int'(g_aux);
    end
    chk("t3_beats", n, BURST_MAX);
    cycle();
    chk("t3_cpu_after", g_cpu, 1);
    set_cpu(0, 0, 0, 0); set_aux(0, 0, 0, 0, 0);
    cycle();

    // T4: lock drops after 3 beats while CPU waits
    set_aux(1, 0, 1, 32'h100, 0);
    cycle();
    set_cpu(1, 0, 32'h200, 0);
    cycle();
    cycle();
    chk("t4_beat3", g_aux, 1);
    aux_lock_i = 0;
    cycle();
    chk("t4_cpu", g_cpu, 1);
    chk("t4_beat_cnt", dut.beat_cnt, 0);
    set_cpu(0, 0, 0, 0); set_aux(0, 0, 0, 0, 0);
    cycle();

    // T5: reset mid-burst, then CPU wins the first contended cycle
    set_aux(1, 1, 1, 32'h300, 32'h5);
    for (int c = 0; c < 5; c++) cycle();
    RST = 1'b1;
    cycle();
    chk("t5_wren", g_wren, 0);
    chk("t5_gnt", {g_cpu, g_aux}, 0);
    RST = 1'b0;
    set_cpu(1, 0, 32'h400, 0);
    cycle();
    chk("t5_cpu_first", g_cpu, 1);
    set_cpu(0, 0, 0, 0); set_aux(0, 0, 0, 0, 0);
    cycle();

    // T6: lone aux write
    set_aux(1, 1, 0, 262144, 77);
    cycle();
    chk("t6_wren", g_wren, 1);
    set_aux(0, 0, 0, 0, 0);
    #1;
    chk("t6_no_rvalid", aux_rvalid_o, 0);
    cycle();

    // Random traffic: requesters hold their request until granted
    cpu_pend = 0; aux_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 99) == 0);
      if (!cpu_pend && $urandom_range(0, 1) == 1) begin
        set_cpu(1, 1'($urandom), $urandom, $urandom); cpu_pend = 1;
      end else if (!cpu_pend) begin
        cpu_req_i = 0;
      end
      if (!aux_pend && $urandom_range(0, 2) != 0) begin
        set_aux(1, 1'($urandom), ($urandom_range(0, 3) != 0), $urandom, $urandom);
        aux_pend = 1;
      end else if (!aux_pend) begin
        aux_req_i = 0;
      end
      mem_data_i = $urandom;
      cycle();
      if (e_cpu) begin cpu_pend = 0; cpu_req_i = 0; end
      if (e_aux) begin aux_pend = 0; aux_req_i = 0; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
